// File: rtl/sram_pkg.sv
// Shared types and elaboration helpers for the masked 1R1W SRAM model.
package sram_pkg;

    // Init engine state: clearing the array, or serving requests.
    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } sram_state_e;

    // Number of write-mask segments for a given word width and segment size.
    function automatic int mask_width(input int width, input int gran);
        return width / gran;
    endfunction

    // True when the parameter set describes a buildable array.
    function automatic bit params_ok(input int depth, input int width,
                                     input int gran, input int read_lat);
        return (depth >= 32'sd2) && (gran > 32'sd0) &&
               ((width % gran) == 32'sd0) &&
               ((read_lat == 32'sd1) || (read_lat == 32'sd2));
    endfunction

endpackage

// File: rtl/sram_1r1w_core.sv
// Reset-free storage array with a per-segment masked write port and a
// synchronous read port (address sampled on the edge, data held in a read
// register until the next accepted read).
module sram_1r1w_core
    import sram_pkg::*;
#(
    parameter int DEPTH     = 32,
    parameter int WIDTH     = 25,
    parameter int MASK_GRAN = 25,
    localparam int MASK_W   = mask_width(WIDTH, MASK_GRAN),
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [MASK_W-1:0] wr_mask,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;
    logic [WIDTH-1:0] wr_word_d;
    logic [AW-1:0]    wr_idx_s;
    logic [AW-1:0]    rd_idx_s;
    logic             wr_in_range_s;
    logic             rd_in_range_s;

    assign wr_in_range_s = ({1'b0, wr_addr} < DEPTH_V);
    assign rd_in_range_s = ({1'b0, rd_addr} < DEPTH_V);

    // Merge the masked segments of the incoming word into the stored entry.
    always_comb begin
        if (wr_in_range_s) begin
            wr_idx_s = wr_addr;
        end else begin
            wr_idx_s = '0;
        end
        wr_word_d = mem_q[wr_idx_s];
        for (int i = 0; i < MASK_W; i++) begin
            if (wr_mask[i]) begin
                wr_word_d[i*MASK_GRAN +: MASK_GRAN] = wr_data[i*MASK_GRAN +: MASK_GRAN];
            end else begin
                wr_word_d[i*MASK_GRAN +: MASK_GRAN] = mem_q[wr_idx_s][i*MASK_GRAN +: MASK_GRAN];
            end
        end
    end

    // Storage update; out-of-range writes never touch the array.
    always_ff @(posedge clock) begin
        if (wr_en && wr_in_range_s) begin
            mem_q[wr_idx_s] <= wr_word_d;
        end
    end

    // Read register: loads the pre-edge contents on an in-range read, else holds.
    always_comb begin
        if (rd_in_range_s) begin
            rd_idx_s = rd_addr;
        end else begin
            rd_idx_s = '0;
        end
        if (rd_en && rd_in_range_s) begin
            rd_data_d = mem_q[rd_idx_s];
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Read data register (storage-side, no reset).
    always_ff @(posedge clock) begin
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sram_1r1w_masked.sv
// 1R1W SRAM model: init FSM that zero-fills the array after reset, write mux
// between the init engine and W0, write-first forwarding into the read path,
// and a 1- or 2-cycle read response pipeline.
module sram_1r1w_masked
    import sram_pkg::*;
#(
    parameter int DEPTH         = 32,
    parameter int WIDTH         = 25,
    parameter int MASK_GRAN     = 25,
    parameter int READ_LAT      = 1,
    parameter int INIT_ON_RESET = 1,
    localparam int MASK_W       = mask_width(WIDTH, MASK_GRAN),
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              R0_en,
    input  logic [AW-1:0]     R0_addr,
    output logic [WIDTH-1:0]  R0_data,
    output logic              R0_valid,
    input  logic              W0_en,
    input  logic [AW-1:0]     W0_addr,
    input  logic [WIDTH-1:0]  W0_data,
    input  logic [MASK_W-1:0] W0_mask,
    output logic              init_done
);

    if (!params_ok(DEPTH, WIDTH, MASK_GRAN, READ_LAT)) begin : g_bad_params
        $error("sram_1r1w_masked: WIDTH must be a multiple of MASK_GRAN, READ_LAT 1 or 2, DEPTH >= 2");
    end

    localparam logic [AW:0]    DEPTH_V   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]  LAST_PTR  = AW'(DEPTH - 1);
    localparam sram_state_e    RST_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
    localparam logic           RST_DONE  = (INIT_ON_RESET != 0) ? 1'b0 : 1'b1;

    sram_state_e      state_q, state_d;
    logic [AW-1:0]    init_ptr_q, init_ptr_d;
    logic             init_done_q, init_done_d;

    logic             rd_acc_s;
    logic             wr_acc_s;
    logic             rd_oor_s;
    logic             fwd_hit_s;
    logic [WIDTH-1:0] fwd_bits_s;

    logic              core_wr_en_s;
    logic [AW-1:0]     core_wr_addr_s;
    logic [WIDTH-1:0]  core_wr_data_s;
    logic [MASK_W-1:0] core_wr_mask_s;
    logic [WIDTH-1:0]  core_rd_data_s;

    logic             v1_q, v1_d;
    logic             seen1_q, seen1_d;
    logic             oor1_q, oor1_d;
    logic [WIDTH-1:0] fwd_bits1_q, fwd_bits1_d;
    logic [WIDTH-1:0] fwd_data1_q, fwd_data1_d;
    logic [WIDTH-1:0] merged_s;

    logic             v2_q, v2_d;
    logic [WIDTH-1:0] data2_q, data2_d;

    // Init FSM next state: walk init_ptr over every entry, then serve requests.
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        case (state_q)
            ST_INIT: begin
                if (init_ptr_q == LAST_PTR) begin
                    state_d    = ST_READY;
                    init_ptr_d = '0;
                end else begin
                    state_d    = ST_INIT;
                    init_ptr_d = init_ptr_q + AW'(1);
                end
            end
            ST_READY: begin
                state_d    = ST_READY;
                init_ptr_d = init_ptr_q;
            end
            default: begin
                state_d    = ST_INIT;
                init_ptr_d = '0;
            end
        endcase
        init_done_d = (state_d == ST_READY);
    end

    // Init FSM state register; reset restarts the clearing sweep from entry 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= RST_STATE;
            init_ptr_q  <= '0;
            init_done_q <= RST_DONE;
        end else begin
            state_q     <= state_d;
            init_ptr_q  <= init_ptr_d;
            init_done_q <= init_done_d;
        end
    end

    assign rd_acc_s  = R0_en & init_done_q;
    assign wr_acc_s  = W0_en & init_done_q;
    assign rd_oor_s  = ({1'b0, R0_addr} >= DEPTH_V);
    assign fwd_hit_s = rd_acc_s & wr_acc_s & (W0_addr == R0_addr);

    // Write mux: the init engine owns the port until the array is cleared.
    always_comb begin
        if (state_q == ST_INIT) begin
            core_wr_en_s   = 1'b1;
            core_wr_addr_s = init_ptr_q;
            core_wr_data_s = '0;
            core_wr_mask_s = {MASK_W{1'b1}};
        end else begin
            core_wr_en_s   = wr_acc_s;
            core_wr_addr_s = W0_addr;
            core_wr_data_s = W0_data;
            core_wr_mask_s = W0_mask;
        end
    end

    // Bit mask of the segments a same-edge write hands straight to the read.
    always_comb begin
        fwd_bits_s = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (fwd_hit_s && W0_mask[i]) begin
                fwd_bits_s[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{1'b1}};
            end else begin
                fwd_bits_s[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{1'b0}};
            end
        end
    end

    sram_1r1w_core #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .MASK_GRAN (MASK_GRAN)
    ) u_core (
        .clock   (clock),
        .wr_en   (core_wr_en_s),
        .wr_addr (core_wr_addr_s),
        .wr_data (core_wr_data_s),
        .wr_mask (core_wr_mask_s),
        .rd_en   (rd_acc_s),
        .rd_addr (R0_addr),
        .rd_data (core_rd_data_s)
    );

    // Stage-1 response side info: captured with each accepted read, held otherwise.
    always_comb begin
        v1_d = rd_acc_s;
        if (rd_acc_s) begin
            seen1_d     = 1'b1;
            oor1_d      = rd_oor_s;
            fwd_bits1_d = fwd_bits_s;
            fwd_data1_d = W0_data & fwd_bits_s;
        end else begin
            seen1_d     = seen1_q;
            oor1_d      = oor1_q;
            fwd_bits1_d = fwd_bits1_q;
            fwd_data1_d = fwd_data1_q;
        end
    end

    // Merge: old contents for unwritten segments, forwarded data for written
    // ones; zero before the first response and for out-of-range reads.
    always_comb begin
        if (!seen1_q || oor1_q) begin
            merged_s = '0;
        end else begin
            merged_s = (core_rd_data_s & ~fwd_bits1_q) | fwd_data1_q;
        end
    end

    // Stage-2 output register used when the extra read cycle is configured.
    always_comb begin
        v2_d = v1_q;
        if (v1_q) begin
            data2_d = merged_s;
        end else begin
            data2_d = data2_q;
        end
    end

    // Response pipeline registers; reset drops anything in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v1_q        <= 1'b0;
            seen1_q     <= 1'b0;
            oor1_q      <= 1'b0;
            fwd_bits1_q <= '0;
            fwd_data1_q <= '0;
            v2_q        <= 1'b0;
            data2_q     <= '0;
        end else begin
            v1_q        <= v1_d;
            seen1_q     <= seen1_d;
            oor1_q      <= oor1_d;
            fwd_bits1_q <= fwd_bits1_d;
            fwd_data1_q <= fwd_data1_d;
            v2_q        <= v2_d;
            data2_q     <= data2_d;
        end
    end

    // Output select by configured read latency.
    always_comb begin
        if (READ_LAT == 2) begin
            R0_valid = v2_q;
            R0_data  = data2_q;
        end else begin
            R0_valid = v1_q;
            R0_data  = merged_s;
        end
    end

    assign init_done = init_done_q;

endmodule

// File: tb/tb_sram_1r1w_masked.sv
// Directed bench: instance A (DEPTH 32, 32-bit, byte mask, 1-cycle read) and
// instance B (DEPTH 20, 32-bit, byte mask, 2-cycle read).
module tb_sram_1r1w_masked;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        a_r_en = 1'b0;
    logic [4:0]  a_r_addr = 5'd0;
    logic [31:0] a_r_data;
    logic        a_r_valid;
    logic        a_w_en = 1'b0;
    logic [4:0]  a_w_addr = 5'd0;
    logic [31:0] a_w_data = 32'h0;
    logic [3:0]  a_w_mask = 4'h0;
    logic        a_done;

    logic        b_r_en = 1'b0;
    logic [4:0]  b_r_addr = 5'd0;
    logic [31:0] b_r_data;
    logic        b_r_valid;
    logic        b_w_en = 1'b0;
    logic [4:0]  b_w_addr = 5'd0;
    logic [31:0] b_w_data = 32'h0;
    logic [3:0]  b_w_mask = 4'h0;
    logic        b_done;

    int n_cmp = 0;
    int n_bad = 0;

    sram_1r1w_masked #(.DEPTH(32), .WIDTH(32), .MASK_GRAN(8), .READ_LAT(1), .INIT_ON_RESET(1)) dut_a (
        .clock(clock), .reset(reset),
        .R0_en(a_r_en), .R0_addr(a_r_addr), .R0_data(a_r_data), .R0_valid(a_r_valid),
        .W0_en(a_w_en), .W0_addr(a_w_addr), .W0_data(a_w_data), .W0_mask(a_w_mask),
        .init_done(a_done)
    );

    sram_1r1w_masked #(.DEPTH(20), .WIDTH(32), .MASK_GRAN(8), .READ_LAT(2), .INIT_ON_RESET(1)) dut_b (
        .clock(clock), .reset(reset),
        .R0_en(b_r_en), .R0_addr(b_r_addr), .R0_data(b_r_data), .R0_valid(b_r_valid),
        .W0_en(b_w_en), .W0_addr(b_w_addr), .W0_data(b_w_data), .W0_mask(b_w_mask),
        .init_done(b_done)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (a_r_valid !== 1'b0) begin n_bad++; $display("FAIL rst_a_valid: got %b want 0", a_r_valid); end
        n_cmp++; if (a_r_data !== 32'h0) begin n_bad++; $display("FAIL rst_a_data: got %h want 0", a_r_data); end
        n_cmp++; if (a_done !== 1'b0) begin n_bad++; $display("FAIL rst_a_done: got %b want 0", a_done); end
        n_cmp++; if (b_r_valid !== 1'b0 || b_r_data !== 32'h0) begin n_bad++; $display("FAIL rst_b_out: got %b/%h want 0/0", b_r_valid, b_r_data); end
        tick();
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            if (i == 3) begin
                a_w_en = 1'b1; a_w_addr = 5'd0; a_w_data = 32'hFF; a_w_mask = 4'hF;
                a_r_en = 1'b1; a_r_addr = 5'd0;
            end else begin
                a_w_en = 1'b0; a_r_en = 1'b0;
            end
            tick();
            n_cmp++; if (a_done !== (i >= 32)) begin n_bad++; $display("FAIL init_a_done c%0d: got %b want %b", i, a_done, (i >= 32)); end
            n_cmp++; if (b_done !== (i >= 20)) begin n_bad++; $display("FAIL init_b_done c%0d: got %b want %b", i, b_done, (i >= 20)); end
            if (i == 4) begin
                n_cmp++; if (a_r_valid !== 1'b0) begin n_bad++; $display("FAIL init_read_dropped: got %b want 0", a_r_valid); end
            end
        end
        a_w_en = 1'b0; a_r_en = 1'b0;
    endtask

    task automatic test_first_reads();
        a_r_en = 1'b1; a_r_addr = 5'd5;
        tick();
        n_cmp++; if (a_r_valid !== 1'b1 || a_r_data !== 32'h0) begin n_bad++; $display("FAIL read5: got %b/%h want 1/00000000", a_r_valid, a_r_data); end
        a_r_addr = 5'd0;
        tick();
        n_cmp++; if (a_r_valid !== 1'b1 || a_r_data !== 32'h0) begin n_bad++; $display("FAIL init_write_dropped: got %b/%h want 1/00000000", a_r_valid, a_r_data); end
        a_r_en = 1'b0;
        tick();
        n_cmp++; if (a_r_valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid: got %b want 0", a_r_valid); end
    endtask

    task automatic test_mask();
        a_w_en = 1'b1; a_w_addr = 5'd3; a_w_data = 32'hAABBCCDD; a_w_mask = 4'hF;
        tick();
        a_w_data = 32'h11223344; a_w_mask = 4'h5;
        tick();
        a_w_data = 32'hFFFFFFFF; a_w_mask = 4'h0;
        tick();
        a_w_en = 1'b0;
        a_r_en = 1'b1; a_r_addr = 5'd3;
        tick();
        n_cmp++; if (a_r_valid !== 1'b1 || a_r_data !== 32'hAA22CC44) begin n_bad++; $display("FAIL mask_merge: got %b/%h want 1/aa22cc44", a_r_valid, a_r_data); end
        a_r_en = 1'b0;
        a_w_en = 1'b1; a_w_addr = 5'd3; a_w_data = 32'h0; a_w_mask = 4'hF;
        tick();
        n_cmp++; if (a_r_valid !== 1'b0 || a_r_data !== 32'hAA22CC44) begin n_bad++; $display("FAIL data_hold: got %b/%h want 0/aa22cc44", a_r_valid, a_r_data); end
        a_w_data = 32'hAA22CC44;
        tick();
        a_w_en = 1'b0;
    endtask

    task automatic test_forward();
        a_w_en = 1'b1; a_w_addr = 5'd7; a_w_data = 32'h12345678; a_w_mask = 4'h3;
        a_r_en = 1'b1; a_r_addr = 5'd7;
        tick();
        n_cmp++; if (a_r_valid !== 1'b1 || a_r_data !== 32'h00005678) begin n_bad++; $display("FAIL fwd_same_edge: got %b/%h want 1/00005678", a_r_valid, a_r_data); end
        a_w_en = 1'b0;
        tick();
        n_cmp++; if (a_r_valid !== 1'b1 || a_r_data !== 32'h00005678) begin n_bad++; $display("FAIL fwd_stored: got %b/%h want 1/00005678", a_r_valid, a_r_data); end
        a_r_en = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        a_w_en = 1'b1; a_w_mask = 4'hF; a_w_addr = 5'd10; a_w_data = 32'hA0A0A0A0;
        tick();
        a_w_addr = 5'd11; a_w_data = 32'hB1B1B1B1; a_r_en = 1'b1; a_r_addr = 5'd10;
        tick();
        n_cmp++; if (a_r_valid !== 1'b1 || a_r_data !== 32'hA0A0A0A0) begin n_bad++; $display("FAIL b2b_10: got %b/%h want 1/a0a0a0a0", a_r_valid, a_r_data); end
        a_w_addr = 5'd12; a_w_data = 32'hC2C2C2C2; a_r_addr = 5'd11;
        tick();
        n_cmp++; if (a_r_valid !== 1'b1 || a_r_data !== 32'hB1B1B1B1) begin n_bad++; $display("FAIL b2b_11: got %b/%h want 1/b1b1b1b1", a_r_valid, a_r_data); end
        a_w_en = 1'b0; a_r_addr = 5'd12;
        tick();
        n_cmp++; if (a_r_valid !== 1'b1 || a_r_data !== 32'hC2C2C2C2) begin n_bad++; $display("FAIL b2b_12: got %b/%h want 1/c2c2c2c2", a_r_valid, a_r_data); end
        a_r_en = 1'b0;
        tick();
        n_cmp++; if (a_r_valid !== 1'b0 || a_r_data !== 32'hC2C2C2C2) begin n_bad++; $display("FAIL b2b_end: got %b/%h want 0/c2c2c2c2", a_r_valid, a_r_data); end
    endtask

    task automatic test_lat2();
        b_w_en = 1'b1; b_w_mask = 4'hF;
        b_w_addr = 5'd0; b_w_data = 32'h01010101;
        tick();
        b_w_addr = 5'd1; b_w_data = 32'h02020202;
        tick();
        b_w_addr = 5'd2; b_w_data = 32'h03030303;
        tick();
        b_w_en = 1'b0;
        b_r_en = 1'b1; b_r_addr = 5'd0;
        tick();
        n_cmp++; if (b_r_valid !== 1'b0) begin n_bad++; $display("FAIL lat2_early: got %b want 0", b_r_valid); end
        b_r_addr = 5'd1;
        tick();
        n_cmp++; if (b_r_valid !== 1'b1 || b_r_data !== 32'h01010101) begin n_bad++; $display("FAIL lat2_r0: got %b/%h want 1/01010101", b_r_valid, b_r_data); end
        b_r_addr = 5'd2;
        tick();
        n_cmp++; if (b_r_valid !== 1'b1 || b_r_data !== 32'h02020202) begin n_bad++; $display("FAIL lat2_r1: got %b/%h want 1/02020202", b_r_valid, b_r_data); end
        b_r_en = 1'b0;
        tick();
        n_cmp++; if (b_r_valid !== 1'b1 || b_r_data !== 32'h03030303) begin n_bad++; $display("FAIL lat2_r2: got %b/%h want 1/03030303", b_r_valid, b_r_data); end
        tick();
        n_cmp++; if (b_r_valid !== 1'b0 || b_r_data !== 32'h03030303) begin n_bad++; $display("FAIL lat2_end: got %b/%h want 0/03030303", b_r_valid, b_r_data); end
    endtask

    task automatic test_out_of_range();
        b_w_en = 1'b1; b_w_addr = 5'd25; b_w_data = 32'hDEADBEEF; b_w_mask = 4'hF;
        b_r_en = 1'b1; b_r_addr = 5'd25;
        tick();
        b_w_en = 1'b0; b_r_en = 1'b0;
        tick();
        n_cmp++; if (b_r_valid !== 1'b1 || b_r_data !== 32'h0) begin n_bad++; $display("FAIL oor_read: got %b/%h want 1/00000000", b_r_valid, b_r_data); end
        tick();
        n_cmp++; if (b_r_valid !== 1'b0 || b_r_data !== 32'h0) begin n_bad++; $display("FAIL oor_after: got %b/%h want 0/00000000", b_r_valid, b_r_data); end
    endtask

    task automatic test_reset_midflight();
        a_r_en = 1'b1; a_r_addr = 5'd3;
        b_r_en = 1'b1; b_r_addr = 5'd1;
        tick();
        n_cmp++; if (a_r_valid !== 1'b1 || a_r_data !== 32'hAA22CC44) begin n_bad++; $display("FAIL mid_a_pre: got %b/%h want 1/aa22cc44", a_r_valid, a_r_data); end
        a_r_en = 1'b0; b_r_en = 1'b0;
        reset = 1'b1;
        #1;
        n_cmp++; if (a_r_valid !== 1'b0 || a_r_data !== 32'h0) begin n_bad++; $display("FAIL mid_a_async: got %b/%h want 0/00000000", a_r_valid, a_r_data); end
        n_cmp++; if (b_r_valid !== 1'b0 || b_r_data !== 32'h0) begin n_bad++; $display("FAIL mid_b_async: got %b/%h want 0/00000000", b_r_valid, b_r_data); end
        n_cmp++; if (a_done !== 1'b0 || b_done !== 1'b0) begin n_bad++; $display("FAIL mid_done_async: got %b/%b want 0/0", a_done, b_done); end
        tick();
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            n_cmp++; if (b_r_valid !== 1'b0 || a_r_valid !== 1'b0) begin n_bad++; $display("FAIL mid_no_resp c%0d: got %b/%b want 0/0", i, a_r_valid, b_r_valid); end
            n_cmp++; if (a_done !== (i >= 32)) begin n_bad++; $display("FAIL reinit_a_done c%0d: got %b want %b", i, a_done, (i >= 32)); end
            n_cmp++; if (b_done !== (i >= 20)) begin n_bad++; $display("FAIL reinit_b_done c%0d: got %b want %b", i, b_done, (i >= 20)); end
        end
        a_r_en = 1'b1; a_r_addr = 5'd3;
        b_r_en = 1'b1; b_r_addr = 5'd1;
        tick();
        a_r_en = 1'b0; b_r_en = 1'b0;
        n_cmp++; if (a_r_valid !== 1'b1 || a_r_data !== 32'h0) begin n_bad++; $display("FAIL reinit_a_clear: got %b/%h want 1/00000000", a_r_valid, a_r_data); end
        tick();
        n_cmp++; if (b_r_valid !== 1'b1 || b_r_data !== 32'h0) begin n_bad++; $display("FAIL reinit_b_clear: got %b/%h want 1/00000000", b_r_valid, b_r_data); end
    endtask

    initial begin
        test_reset();
        test_first_reads();
        test_mask();
        test_forward();
        test_back_to_back();
        test_lat2();
        test_out_of_range();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
